adder_sweep_checker: RTL and testbench

//   Sequential stimulus generator and response checker for four_bit_adder.

---
 rtl/adder_sweep_checker.sv | 142 ++++++++++++++
 tb/tb_adder_sweep_checker.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/adder_sweep_checker.sv
// On-chip self-test for an adder: sweeps every {A,B} operand pair, holds each
// pair for a settle window, then checks SUM and records mismatch statistics.
module adder_sweep_checker #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               START,
  output logic [WIDTH-1:0]   A,
  output logic [WIDTH-1:0]   B,
  input  logic [WIDTH:0]     SUM,
  output logic               BUSY,
  output logic               DONE,
  output logic               PASS,
  output logic [2*WIDTH:0]   ERR_COUNT,
  output logic               FAIL_VALID,
  output logic [2*WIDTH-1:0] FIRST_FAIL
);

  localparam int VEC_W      = 2 * WIDTH;
  localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam int CNT_W      = (SETTLE_EFF < 2) ? 1 : $clog2(SETTLE_EFF + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_EFF - 1);
  localparam logic [VEC_W:0]   ERR_MAX  = {1'b1, {VEC_W{1'b0}}};
  localparam logic [VEC_W-1:0] VEC_LAST = {VEC_W{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [VEC_W:0]   err_q, err_d;
  logic             fv_q, fv_d;
  logic [VEC_W-1:0] ff_q, ff_d;
  logic [WIDTH:0]   ref_sum;

  // Error count saturates at the number of vectors; it can never exceed it.
  function automatic logic [VEC_W:0] err_inc(input logic [VEC_W:0] cnt);
    return (cnt == ERR_MAX) ? cnt : cnt + 1'b1;
  endfunction

  assign ref_sum = {1'b0, a_q} + {1'b0, b_q};

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fv_d    = fv_q;
    ff_d    = ff_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          state_d = S_SETTLE;
          vec_d   = '0;
          cnt_d   = '0;
          a_d     = '0;
          b_d     = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = '0;
          fv_d    = 1'b0;
          ff_d    = '0;
        end
      end
      S_SETTLE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (SUM != ref_sum) begin
          err_d = err_inc(err_q);
          if (!fv_q) begin
            fv_d = 1'b1;
            ff_d = vec_q;
          end
        end
        // The last compare lands in the same edge that raises DONE.
        if (vec_q == VEC_LAST) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          vec_d   = vec_q + 1'b1;
          cnt_d   = '0;
          a_d     = vec_d[VEC_W-1:WIDTH];
          b_d     = vec_d[WIDTH-1:0];
          state_d = S_SETTLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      ff_q    <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      ff_q    <= ff_d;
    end
  end

  assign A          = a_q;
  assign B          = b_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign PASS       = pass_q;
  assign ERR_COUNT  = err_q;
  assign FAIL_VALID = fv_q;
  assign FIRST_FAIL = ff_q;

endmodule

// File: tb/tb_adder_sweep_checker.sv
// Bench for adder_sweep_checker: a behavioural adder with selectable faults feeds
// SUM back; expected sweep results are queued at START and compared at DONE.
module tb_adder_sweep_checker;
  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, start, start3;
  logic [W-1:0]   a, b, a3, b3;
  logic [W:0]     sum, sum3;
  logic           busy, done, pass, fv, busy3, done3, pass3, fv3;
  logic [2*W:0]   err, err3;
  logic [2*W-1:0] ff, ff3;
  int             fault_mode;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    int err;
    int ff;
    bit fv;
    bit pass;
    int edges;
  } exp_t;
  exp_t sb[$];

  adder_sweep_checker #(.WIDTH(W), .SETTLE_CYCLES(1)) dut (
    .CLK(clk), .RESET(rst), .START(start), .A(a), .B(b), .SUM(sum),
    .BUSY(busy), .DONE(done), .PASS(pass), .ERR_COUNT(err),
    .FAIL_VALID(fv), .FIRST_FAIL(ff)
  );

  adder_sweep_checker #(.WIDTH(W), .SETTLE_CYCLES(3)) dut3 (
    .CLK(clk), .RESET(rst), .START(start3), .A(a3), .B(b3), .SUM(sum3),
    .BUSY(busy3), .DONE(done3), .PASS(pass3), .ERR_COUNT(err3),
    .FAIL_VALID(fv3), .FIRST_FAIL(ff3)
  );

  // Adder under test: 0 golden, 1 SUM[0] stuck low, 2 wrong only at 15+15.
  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    if (fault_mode == 1) sum[0] = 1'b0;
    else if (fault_mode == 2 && a == 4'd15 && b == 4'd15) sum = '0;
  end
  always_comb sum3 = {1'b0, a3} + {1'b0, b3};

  function automatic void model(input int mode, output int e_err, output int e_ff);
    e_err = 0;
    e_ff  = 0;
    for (int v = 0; v < 256; v++) begin
      int x, y, s, got;
      x = v / 16;
      y = v % 16;
      s = x + y;
      got = s;
      if (mode == 1) got = s - (s % 2);
      if (mode == 2 && x == 15 && y == 15) got = 0;
      if (got != s) begin
        if (e_err == 0) e_ff = v;
        e_err++;
      end
    end
  endfunction

  task automatic do_sweep(input int mode, input bit use3, input bit mid_start, input string nm);
    exp_t e, got;
    int   settle, k, m_err, m_ff, vec_obs;
    bit   ab_bad, busy_bad, fv_before, done_o, busy_o;
    settle = use3 ? 3 : 1;
    if (!use3) fault_mode = mode;
    model(mode, m_err, m_ff);
    e.err   = m_err;
    e.ff    = m_ff;
    e.fv    = (m_err != 0);
    e.pass  = (m_err == 0);
    e.edges = 256 * (settle + 1);
    sb.push_back(e);

    @(negedge clk);
    if (use3) start3 = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start3 = 1'b0;
    n_total++;
    if (use3 ? !(busy3 === 1'b1 && done3 === 1'b0 && err3 === '0 && fv3 === 1'b0 && pass3 === 1'b0)
             : !(busy  === 1'b1 && done  === 1'b0 && err  === '0 && fv  === 1'b0 && pass  === 1'b0))
      $display("FAIL %s.start_edge busy=%b done=%b err=%0d fv=%b required busy=1 done=0 err=0 fv=0",
               nm, use3 ? busy3 : busy, use3 ? done3 : done, use3 ? err3 : err, use3 ? fv3 : fv);
    else n_pass++;

    k = 0;
    ab_bad = 1'b0;
    busy_bad = 1'b0;
    fv_before = 1'b0;
    done_o = 1'b0;
    while (k < 3000) begin
      vec_obs = use3 ? int'({a3, b3}) : int'({a, b});
      if (vec_obs != k / (settle + 1)) begin
        if (!ab_bad) $display("note %s: edge %0d A/B=%0h expected %0h", nm, k, vec_obs, k / (settle + 1));
        ab_bad = 1'b1;
      end
      fv_before = use3 ? fv3 : fv;
      @(posedge clk); #1;
      k++;
      if (mid_start) start = (k == 100);
      done_o = use3 ? done3 : done;
      busy_o = use3 ? busy3 : busy;
      if (done_o) break;
      if (busy_o !== 1'b1) busy_bad = 1'b1;
    end
    start = 1'b0;

    got = sb.pop_front();
    n_total++;
    if (!done_o || k != got.edges)
      $display("FAIL %s.done_edge actual=%0d (done=%b) required=%0d", nm, k, done_o, got.edges);
    else n_pass++;
    n_total++;
    if (ab_bad) $display("FAIL %s.ab_sequence actual=bad required=vec held %0d cycles", nm, settle + 1);
    else n_pass++;
    n_total++;
    if (busy_bad) $display("FAIL %s.busy_held actual=dropped required=1 until DONE", nm);
    else n_pass++;
    n_total++;
    if (int'(use3 ? err3 : err) !== got.err)
      $display("FAIL %s.err_count actual=%0d required=%0d", nm, use3 ? err3 : err, got.err);
    else n_pass++;
    n_total++;
    if (int'(use3 ? ff3 : ff) !== got.ff)
      $display("FAIL %s.first_fail actual=%0h required=%0h", nm, use3 ? ff3 : ff, got.ff);
    else n_pass++;
    n_total++;
    if ((use3 ? fv3 : fv) !== got.fv)
      $display("FAIL %s.fail_valid actual=%b required=%b", nm, use3 ? fv3 : fv, got.fv);
    else n_pass++;
    n_total++;
    if ((use3 ? pass3 : pass) !== got.pass || busy_o !== 1'b0)
      $display("FAIL %s.pass actual=%b busy=%b required pass=%b busy=0", nm, use3 ? pass3 : pass, busy_o, got.pass);
    else n_pass++;
    if (mode == 2) begin
      n_total++;
      if (fv_before !== 1'b0)
        $display("FAIL %s.fv_before_last actual=%b required=0", nm, fv_before);
      else n_pass++;
    end
  endtask

  task automatic check_all_zero(input string nm);
    n_total++;
    if ({a, b, busy, done, pass, err, fv, ff} !== '0)
      $display("FAIL %s actual A=%0h B=%0h busy=%b done=%b pass=%b err=%0d fv=%b ff=%0h required all 0",
               nm, a, b, busy, done, pass, err, fv, ff);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    start3 = 1'b0;
    fault_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("idle_hold");
  endtask

  task automatic test_reset_mid();
    int k;
    fault_mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while ({a, b} != 8'h40 && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    n_total++;
    if ({a, b} != 8'h40) $display("FAIL reset_mid.reach_40 actual=%0h required=40", {a, b});
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    check_all_zero("reset_mid.async");
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_all_zero("reset_mid.idle");
    do_sweep(0, 1'b0, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    do_sweep(0, 1'b0, 1'b0, "golden");
    do_sweep(1, 1'b0, 1'b0, "stuck_sum0");
    do_sweep(2, 1'b0, 1'b0, "last_vector");
    do_sweep(0, 1'b1, 1'b0, "settle3");
    test_reset_mid();
    do_sweep(0, 1'b0, 1'b1, "mid_start");
    do_sweep(1, 1'b0, 1'b0, "b2b_first");
    do_sweep(0, 1'b0, 1'b0, "b2b_second");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
